// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory among NumOfRequesters requesters.
// Each transaction is a REQ -> GRANT (1-cycle ACCESS) -> ACK (1-cycle RESP)
// handshake; read data is captured at the end of ACCESS.
// Build option: define MEM_ARB_FIXED_PRIORITY_EN for lowest-index-wins
// priority (no pointer); undefined gives round-robin arbitration.
module mem_arbiter #(
    parameter int DataWidth       = 8,
    parameter int NumOfRequesters = 4
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [NumOfRequesters-1:0]           REQ,
    input  logic [NumOfRequesters-1:0]           REQ_WRITE,
    input  logic [NumOfRequesters*DataWidth-1:0] REQ_ADDR,
    input  logic [NumOfRequesters*DataWidth-1:0] REQ_DATA,
    output logic [NumOfRequesters-1:0]           GRANT,
    output logic [NumOfRequesters-1:0]           ACK,
    output logic [DataWidth-1:0]                 RDATA,
    output logic                                 BUSY,
    output logic [DataWidth-1:0]                 MEM_ADDR,
    output logic [DataWidth-1:0]                 MEM_DATA_IN,
    output logic                                 MEM_WRITE,
    input  logic [DataWidth-1:0]                 MEM_DATA_OUT
);
    localparam int N    = NumOfRequesters;
    localparam int IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

    state_e               state_q;
    logic [N-1:0]         grant_q;
    logic [N-1:0]         ack_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 busy_q;
    logic [IdxW-1:0]      gidx_q;
    logic [IdxW-1:0]      win_d;
    logic [N-1:0]         win_oh_d;

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    logic [IdxW-1:0]      ptr_q;
    logic                 found_d;
    int unsigned          cand_d;
`endif

    // Pick the winning requester from the current REQ vector
    always_comb begin
        win_d = '0;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        // downward scan: the lowest requesting index is assigned last and wins
        for (int unsigned i = N; i > 0; i--) begin
            if (REQ[i-1]) win_d = IdxW'(i - 1);
        end
`else
        found_d = 1'b0;
        cand_d  = 0;
        // search starts just after the last grant and wraps modulo N
        for (int unsigned k = 1; k <= N; k++) begin
            cand_d = 32'(ptr_q) + k;
            if (cand_d >= N) cand_d = cand_d - N;
            if (!found_d && REQ[cand_d]) begin
                win_d   = IdxW'(cand_d);
                found_d = 1'b1;
            end
        end
`endif
    end

    // One-hot form of the winner index
    always_comb begin
        win_oh_d        = '0;
        win_oh_d[win_d] = 1'b1;
    end

    // Route the granted requester to the memory pins during ACCESS only;
    // gating with RST keeps a reset edge in ACCESS from committing a write
    always_comb begin
        MEM_ADDR    = '0;
        MEM_DATA_IN = '0;
        MEM_WRITE   = 1'b0;
        if (state_q == ST_ACCESS && !RST) begin
            MEM_ADDR    = REQ_ADDR[int'(gidx_q)*DataWidth +: DataWidth];
            MEM_DATA_IN = REQ_DATA[int'(gidx_q)*DataWidth +: DataWidth];
            MEM_WRITE   = REQ_WRITE[gidx_q];
        end
    end

    // Handshake FSM with registered GRANT/ACK/RDATA/BUSY
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            gidx_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            ptr_q   <= IdxW'(N - 1);
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= '0;
                    if (|REQ) begin
                        grant_q <= win_oh_d;
                        gidx_q  <= win_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rdata_q <= MEM_DATA_OUT;
                    ack_q   <= grant_q;
                    grant_q <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
                    ptr_q   <= gidx_q;
`endif
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign GRANT = grant_q;
    assign ACK   = ack_q;
    assign RDATA = rdata_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a 16-entry memory model on the MEM_* pins and a
// transaction-level reference model (arbitration rule + shadow memory).
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic            CLK, RST;
    logic [N-1:0]    REQ, REQ_WRITE, GRANT, ACK;
    logic [N*DW-1:0] REQ_ADDR, REQ_DATA;
    logic [DW-1:0]   RDATA, MEM_ADDR, MEM_DATA_IN, MEM_DATA_OUT;
    logic            BUSY, MEM_WRITE;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.DataWidth(DW), .NumOfRequesters(N)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .GRANT(GRANT), .ACK(ACK),
        .RDATA(RDATA), .BUSY(BUSY), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA_IN(MEM_DATA_IN), .MEM_WRITE(MEM_WRITE),
        .MEM_DATA_OUT(MEM_DATA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared memory: combinational read, write on rising edge; pokes preload it
    logic [DW-1:0] tb_mem [16];
    logic          poke_en;
    logic [3:0]    poke_addr;
    logic [DW-1:0] poke_data;
    assign MEM_DATA_OUT = tb_mem[MEM_ADDR[3:0]];
    always @(posedge CLK) begin
        if (poke_en) tb_mem[poke_addr] <= poke_data;
        else if (MEM_WRITE) tb_mem[MEM_ADDR[3:0]] <= MEM_DATA_IN;
    end

    // Reference model: a grant may start once the previous transaction's
    // 3-cycle slot has elapsed; the winner follows the arbitration rule.
    logic [DW-1:0] ref_mem [16];
    longint        cyc = 0, m_free = 0;
    int            m_ptr = N - 1, m_idx = 0;
    bit            m_pend = 0, m_ackwr = 0;
    logic [N-1:0]  m_grant = '0, m_ack = '0;
    logic [DW-1:0] m_rdata = '0, m_a = '0, m_d = '0;
    logic          m_busy = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        int w = -1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        for (int i = N - 1; i >= 0; i--) if (r[i]) w = i;
`else
        for (int k = N; k >= 1; k--) if (r[(ptr + k) % N]) w = (ptr + k) % N;
`endif
        return w;
    endfunction

    always @(posedge CLK) begin
        if (poke_en) ref_mem[poke_addr] = poke_data;
        if (RST) begin
            m_grant = '0; m_ack = '0; m_rdata = '0;
            m_ptr = N - 1; m_pend = 0; m_free = cyc + 1;
        end else begin
            m_ack = '0;
            if (m_pend) begin
                m_a     = REQ_ADDR[m_idx*DW +: DW];
                m_d     = REQ_DATA[m_idx*DW +: DW];
                m_ackwr = REQ_WRITE[m_idx];
                m_rdata = ref_mem[m_a[3:0]];
                if (m_ackwr) ref_mem[m_a[3:0]] = m_d;
                m_ack   = m_grant;
                m_grant = '0;
                m_ptr   = m_idx;
                m_pend  = 0;
            end else if (cyc >= m_free && REQ != '0) begin
                m_idx          = pick(REQ, m_ptr);
                m_grant        = '0;
                m_grant[m_idx] = 1'b1;
                m_pend         = 1;
                m_free         = cyc + 3;
            end
        end
        m_busy = (m_grant != '0) || (m_ack != '0);
        cyc++;
    end

    task automatic set_req(input int i, input logic on, input logic w,
                           input logic [DW-1:0] a, input logic [DW-1:0] d);
        REQ[i]            = on;
        REQ_WRITE[i]      = w;
        REQ_ADDR[i*DW +: DW] = a;
        REQ_DATA[i*DW +: DW] = d;
    endtask

    task automatic poke(input logic [3:0] a, input logic [DW-1:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge CLK);
        poke_en = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        total++; if (GRANT !== '0) begin bad++; $display("FAIL rst_grant got=%b exp=0", GRANT); end
        total++; if (ACK !== '0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ACK); end
        total++; if (RDATA !== '0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", RDATA); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
        total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL rst_memwrite got=%b exp=0", MEM_WRITE); end
        total++; if (MEM_ADDR !== '0 || MEM_DATA_IN !== '0) begin
            bad++; $display("FAIL rst_memaddr got=%h/%h exp=0/0", MEM_ADDR, MEM_DATA_IN);
        end
        for (int a = 0; a < 16; a++) poke(4'(a), 8'($urandom));
        RST = 1'b0;
    endtask

    task automatic test_single_read();
        poke(4'd5, 8'h3C);
        set_req(2, 1'b1, 1'b0, 8'd5, 8'h00);
        @(negedge CLK);
        total++; if (GRANT !== 4'b0100) begin bad++; $display("FAIL sr_grant got=%b exp=0100", GRANT); end
        total++; if (MEM_ADDR !== 8'd5 || MEM_WRITE !== 1'b0) begin
            bad++; $display("FAIL sr_mem got=%h/%b exp=05/0", MEM_ADDR, MEM_WRITE);
        end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL sr_busy got=%b exp=1", BUSY); end
        @(negedge CLK);
        total++; if (ACK !== 4'b0100) begin bad++; $display("FAIL sr_ack got=%b exp=0100", ACK); end
        total++; if (RDATA !== 8'h3C) begin bad++; $display("FAIL sr_rdata got=%h exp=3c", RDATA); end
        total++; if (GRANT !== '0) begin bad++; $display("FAIL sr_grant_clr got=%b exp=0", GRANT); end
        set_req(2, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge CLK);
        total++; if (ACK !== '0 || BUSY !== 1'b0) begin
            bad++; $display("FAIL sr_idle got=%b/%b exp=0/0", ACK, BUSY);
        end
    endtask

    task automatic test_write_then_read();
        int mw = 0;
        int acks = 0;
        logic [DW-1:0] rd = '0;
        set_req(1, 1'b1, 1'b1, 8'd9, 8'hA5);
        for (int c = 0; c < 12 && acks < 2; c++) begin
            @(negedge CLK);
            if (MEM_WRITE === 1'b1) mw++;
            if (ACK[1] === 1'b1) begin
                acks++;
                rd = RDATA;
                if (acks == 1) set_req(1, 1'b1, 1'b0, 8'd9, 8'h00);
                else set_req(1, 1'b0, 1'b0, 8'd0, 8'd0);
            end
        end
        total++; if (acks != 2) begin bad++; $display("FAIL wr_acks got=%0d exp=2", acks); end
        total++; if (rd !== 8'hA5) begin bad++; $display("FAIL wr_readback got=%h exp=a5", rd); end
        total++; if (mw != 1) begin bad++; $display("FAIL wr_memwrite_cycles got=%0d exp=1", mw); end
        REQ = '0;
        @(negedge CLK);
    endtask

    task automatic test_fairness();
        int ng = 0;
        int last = 0;
        int expg;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 8'(i), 8'h00);
        for (int c = 1; c <= 30; c++) begin
            @(negedge CLK);
            if (GRANT !== '0) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
                expg = 0;
`else
                expg = ng % N;
`endif
                total++; if (GRANT !== 4'(1 << expg)) begin
                    bad++; $display("FAIL rr_order n=%0d got=%b exp=%b", ng, GRANT, 4'(1 << expg));
                end
                if (ng > 0) begin
                    total++; if (c - last != 3) begin
                        bad++; $display("FAIL rr_gap n=%0d got=%0d exp=3", ng, c - last);
                    end
                end
                last = c;
                ng++;
            end
            for (int i = 0; i < N; i++)
                if (ACK[i] === 1'b1) set_req(i, 1'b1, 1'b0, 8'($urandom_range(0, 15)), 8'h00);
        end
        total++; if (ng != 10) begin bad++; $display("FAIL rr_count got=%0d exp=10", ng); end
        REQ = '0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_wrap_skip();
        int ng = 0;
        int acks = 0;
        int seq [3];
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        seq = '{0, 0, 0};
`else
        seq = '{0, 2, 0};
`endif
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'd1, 8'h00);
        set_req(2, 1'b1, 1'b0, 8'd2, 8'h00);
        for (int c = 0; c < 15 && acks < 3; c++) begin
            @(negedge CLK);
            if (GRANT !== '0 && ng < 3) begin
                total++; if (GRANT !== 4'(1 << seq[ng])) begin
                    bad++; $display("FAIL ws_order n=%0d got=%b exp=%b", ng, GRANT, 4'(1 << seq[ng]));
                end
                ng++;
            end
            if (ACK !== '0) begin
                acks++;
                if (acks == 3) REQ = '0;
            end
        end
        total++; if (acks != 3) begin bad++; $display("FAIL ws_acks got=%0d exp=3", acks); end
        REQ = '0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid_access();
        bit got = 0;
        bit acked = 0;
        do_reset();
        poke(4'd7, 8'h11);
        set_req(1, 1'b1, 1'b1, 8'd7, 8'hEE);
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge CLK);
            if (GRANT !== '0) got = 1;
        end
        total++; if (!got) begin bad++; $display("FAIL rma_grant_seen got=0 exp=1"); end
        RST = 1'b1;
        #1;
        total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL rma_memwrite got=%b exp=0", MEM_WRITE); end
        @(negedge CLK);
        total++; if (GRANT !== '0 || ACK !== '0 || BUSY !== 1'b0) begin
            bad++; $display("FAIL rma_clear got=%b/%b/%b exp=0/0/0", GRANT, ACK, BUSY);
        end
        total++; if (tb_mem[7] !== 8'h11) begin bad++; $display("FAIL rma_mem7 got=%h exp=11", tb_mem[7]); end
        RST = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'd3, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'd4, 8'h00);
        @(negedge CLK);
        total++; if (GRANT !== 4'b0001) begin bad++; $display("FAIL rma_first got=%b exp=0001", GRANT); end
        for (int c = 0; c < 4 && !acked; c++) begin
            @(negedge CLK);
            if (ACK !== '0) begin acked = 1; REQ = '0; end
        end
        total++; if (!acked) begin bad++; $display("FAIL rma_ack_seen got=0 exp=1"); end
        REQ = '0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_addr;
        logic          exp_mw;
        REQ = '0;
        @(negedge CLK);
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            total++; if (GRANT !== m_grant) begin bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, GRANT, m_grant); end
            total++; if (ACK !== m_ack) begin bad++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, ACK, m_ack); end
            total++; if (BUSY !== m_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, BUSY, m_busy); end
            exp_addr = (m_grant != '0) ? REQ_ADDR[m_idx*DW +: DW] : '0;
            exp_mw   = (m_grant != '0) ? REQ_WRITE[m_idx] : 1'b0;
            total++; if (MEM_ADDR !== exp_addr || MEM_WRITE !== exp_mw) begin
                bad++; $display("FAIL rnd_mem c=%0d got=%h/%b exp=%h/%b", c, MEM_ADDR, MEM_WRITE, exp_addr, exp_mw);
            end
            if (m_ack != '0 && !m_ackwr) begin
                total++; if (RDATA !== m_rdata) begin
                    bad++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, RDATA, m_rdata);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (ACK[i] === 1'b1) begin
                    if ($urandom_range(0, 1) == 0) set_req(i, 1'b0, 1'b0, 8'd0, 8'd0);
                    else set_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                end else if (REQ[i] !== 1'b1 && $urandom_range(0, 3) == 0) begin
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
                end
            end
        end
        REQ = '0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_DATA = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        test_reset();
        test_single_read();
        test_write_then_read();
        test_fairness();
        test_wrap_skip();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
